// File: rtl/stream_pattern_detector.sv
// Serial frame-based pattern detector: scans FRAME_LEN accepted bits for a
// maskable PAT_W-bit pattern and reports each match start index and a per-frame count.
module stream_pattern_detector #(
  parameter int PAT_W     = 3,
  parameter int FRAME_LEN = 16,
  parameter int IDX_W     = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_overlap,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             match,
  output logic [IDX_W-1:0] match_idx,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             done
);

  localparam int FW = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {IDLE, FILL, SCAN, DONE} state_t;

  state_t           state;
  logic [PAT_W-1:0] hist, pat, mask;
  logic             ovl;
  logic [IDX_W-1:0] pos;
  logic [FW-1:0]    fill;

  logic             accept, full, hit, last;
  logic [PAT_W-1:0] win;

  assign accept = bit_valid && (state == FILL || state == SCAN);
  assign win    = {hist[PAT_W-2:0], bit_in};
  // The incoming bit completes a window once PAT_W-1 fresh bits are already held.
  assign full   = (fill >= FW'(PAT_W - 1));
  assign hit    = accept && full && (((win ^ pat) & mask) == '0);
  assign last   = (pos == IDX_W'(FRAME_LEN - 1));
  assign busy   = (state == FILL) || (state == SCAN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hist      <= '0;
      pat       <= '0;
      mask      <= '0;
      ovl       <= 1'b0;
      pos       <= '0;
      fill      <= '0;
      match     <= 1'b0;
      match_idx <= '0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
      done      <= 1'b0;
    end else begin
      match <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= FILL;
          hist      <= '0;
          pos       <= '0;
          fill      <= '0;
          match_cnt <= '0;
          cnt_sat   <= 1'b0;
          pat       <= cfg_pattern;
          mask      <= cfg_mask;
          ovl       <= cfg_overlap;
        end
        FILL, SCAN: if (accept) begin
          hist <= win;
          pos  <= pos + IDX_W'(1);
          if (hit) begin
            match     <= 1'b1;
            match_idx <= pos - IDX_W'(PAT_W - 1);
            if (&match_cnt) cnt_sat   <= 1'b1;
            else            match_cnt <= match_cnt + CNT_W'(1);
          end
          // Non-overlapping mode discards the whole matched window.
          if (hit && !ovl)               fill <= '0;
          else if (fill != FW'(PAT_W))   fill <= fill + FW'(1);
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (hit && !ovl) begin
            state <= FILL;
          end else if (full) begin
            state <= SCAN;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_pattern_detector.sv
// Scoreboard bench: two detectors (CNT_W=4 and CNT_W=2) share one stimulus stream;
// a bench-side model queues expected matches as bits are driven.
module tb_stream_pattern_detector;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, cfg_overlap, bit_in, bit_valid;
  logic [2:0] cfg_pattern, cfg_mask;

  logic       busy_a, match_a, sat_a, done_a;
  logic [3:0] idx_a, cnt_a;
  logic       busy_b, match_b, sat_b, done_b;
  logic [3:0] idx_b;
  logic [1:0] cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] idx;
    logic [3:0] c4;
    logic       s4;
    logic [1:0] c2;
    logic       s2;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  stream_pattern_detector #(.PAT_W(3), .FRAME_LEN(16), .IDX_W(4), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy_a), .match(match_a), .match_idx(idx_a), .match_cnt(cnt_a),
    .cnt_sat(sat_a), .done(done_a)
  );

  stream_pattern_detector #(.PAT_W(3), .FRAME_LEN(16), .IDX_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy_b), .match(match_b), .match_idx(idx_b), .match_cnt(cnt_b),
    .cnt_sat(sat_b), .done(done_b)
  );

  // One clock; outputs sampled on the falling edge, scoreboard popped on each expected hit.
  task automatic tick(input bit eh, input bit ed);
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({match_a, match_b} !== {eh, eh}) begin
      n_bad++;
      $display("FAIL match_pulse: got %b/%b want %b", match_a, match_b, eh);
    end
    n_cmp++;
    if ({done_a, done_b} !== {ed, ed}) begin
      n_bad++;
      $display("FAIL done_pulse: got %b/%b want %b", done_a, done_b, ed);
    end
    if (eh && q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if (idx_a !== e.idx || cnt_a !== e.c4 || sat_a !== e.s4) begin
        n_bad++;
        $display("FAIL match_a: got idx=%0d cnt=%0d sat=%b want idx=%0d cnt=%0d sat=%b",
                 idx_a, cnt_a, sat_a, e.idx, e.c4, e.s4);
      end
      n_cmp++;
      if (idx_b !== e.idx || cnt_b !== e.c2 || sat_b !== e.s2) begin
        n_bad++;
        $display("FAIL match_b: got idx=%0d cnt=%0d sat=%b want idx=%0d cnt=%0d sat=%b",
                 idx_b, cnt_b, sat_b, e.idx, e.c2, e.s2);
      end
    end
  endtask

  // Drives a frame (bit i of bits = frame index i); nbits<16 leaves the frame unfinished.
  task automatic run_frame(input logic [2:0] pat, input logic [2:0] msk, input bit ovl,
                           input logic [15:0] bits, input int max_gap, input int nbits,
                           input bit poke);
    int         mfill = 0;
    int         mc4 = 0, mc2 = 0;
    bit         ms4 = 0, ms2 = 0, hit;
    logic [2:0] w = '0;
    exp_t       e;
    q.delete();
    start = 1'b1; cfg_pattern = pat; cfg_mask = msk; cfg_overlap = ovl; bit_valid = 1'b0;
    tick(0, 0);
    start = 1'b0;
    cfg_pattern = 3'($urandom); cfg_mask = 3'($urandom); cfg_overlap = ~ovl;
    n_cmp++;
    if ({busy_a, busy_b} !== 2'b11) begin
      n_bad++;
      $display("FAIL busy_after_start: got %b/%b want 1", busy_a, busy_b);
    end
    for (int i = 0; i < nbits; i++) begin
      repeat (max_gap > 0 ? $urandom_range(0, max_gap) : 0) begin
        bit_valid = 1'b0; bit_in = 1'($urandom);
        tick(0, 0);
      end
      bit_in = bits[i]; bit_valid = 1'b1; start = poke && (i == 5);
      w = {w[1:0], bits[i]};
      hit = (mfill + 1 >= 3) && (((w ^ pat) & msk) == 3'b000);
      if (hit) begin
        if (mc4 == 15) ms4 = 1; else mc4++;
        if (mc2 == 3)  ms2 = 1; else mc2++;
        e.idx = 4'(i - 2); e.c4 = 4'(mc4); e.s4 = ms4; e.c2 = 2'(mc2); e.s2 = ms2;
        q.push_back(e);
        mfill = ovl ? 3 : 0;
      end else if (mfill < 3) begin
        mfill++;
      end
      tick(hit, i == 15);
      bit_valid = 1'b0; start = 1'b0;
    end
    if (nbits == 16) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      tick(0, 0);
      bit_valid = 1'b0;
      n_cmp++;
      if ({busy_a, busy_b} !== 2'b00) begin
        n_bad++;
        $display("FAIL busy_after_done: got %b/%b want 0", busy_a, busy_b);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    cfg_pattern = '0; cfg_mask = '0; cfg_overlap = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy_a, match_a, done_a, sat_a, idx_a, cnt_a, busy_b, match_b, done_b, sat_b, idx_b, cnt_b} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got a=%b%b%b%b %0d %0d b=%b%b%b%b %0d %0d want all 0",
               busy_a, match_a, done_a, sat_a, idx_a, cnt_a, busy_b, match_b, done_b, sat_b, idx_b, cnt_b);
    end
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_overlap();
    run_frame(3'b101, 3'b111, 1'b1, 16'h0015, 0, 16, 1'b0);
    n_cmp++;
    if (cnt_a !== 4'd2 || idx_a !== 4'd2 || sat_a !== 1'b0) begin
      n_bad++;
      $display("FAIL overlap_final: got cnt=%0d idx=%0d sat=%b want cnt=2 idx=2 sat=0", cnt_a, idx_a, sat_a);
    end
  endtask

  task automatic test_no_overlap();
    run_frame(3'b101, 3'b111, 1'b0, 16'h0015, 0, 16, 1'b0);
    n_cmp++;
    if (cnt_a !== 4'd1 || idx_a !== 4'd0) begin
      n_bad++;
      $display("FAIL no_overlap_final: got cnt=%0d idx=%0d want cnt=1 idx=0", cnt_a, idx_a);
    end
  endtask

  task automatic test_gaps();
    run_frame(3'b101, 3'b111, 1'b1, 16'h0015, 5, 16, 1'b0);
    n_cmp++;
    if (cnt_a !== 4'd2 || idx_a !== 4'd2) begin
      n_bad++;
      $display("FAIL gaps_final: got cnt=%0d idx=%0d want cnt=2 idx=2", cnt_a, idx_a);
    end
  endtask

  task automatic test_mask();
    run_frame(3'b101, 3'b101, 1'b1, 16'h0007, 0, 16, 1'b0);
    n_cmp++;
    if (cnt_a !== 4'd1 || idx_a !== 4'd0) begin
      n_bad++;
      $display("FAIL mask_partial: got cnt=%0d idx=%0d want cnt=1 idx=0", cnt_a, idx_a);
    end
    run_frame(3'b110, 3'b000, 1'b1, 16'($urandom), 2, 16, 1'b0);
    n_cmp++;
    if (cnt_a !== 4'd14 || sat_a !== 1'b0 || idx_a !== 4'd13) begin
      n_bad++;
      $display("FAIL mask_zero: got cnt=%0d sat=%b idx=%0d want cnt=14 sat=0 idx=13", cnt_a, sat_a, idx_a);
    end
  endtask

  task automatic test_saturate();
    run_frame(3'b111, 3'b111, 1'b1, 16'hFFFF, 0, 16, 1'b0);
    n_cmp++;
    if (cnt_b !== 2'd3 || sat_b !== 1'b1 || idx_b !== 4'd13) begin
      n_bad++;
      $display("FAIL saturate_b: got cnt=%0d sat=%b idx=%0d want cnt=3 sat=1 idx=13", cnt_b, sat_b, idx_b);
    end
    n_cmp++;
    if (cnt_a !== 4'd14 || sat_a !== 1'b0) begin
      n_bad++;
      $display("FAIL saturate_a: got cnt=%0d sat=%b want cnt=14 sat=0", cnt_a, sat_a);
    end
  endtask

  task automatic test_abort();
    run_frame(3'b101, 3'b111, 1'b1, 16'h0055, 0, 7, 1'b0);
    n_cmp++;
    if (cnt_a !== 4'd3 || busy_a !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_pre: got cnt=%0d busy=%b want cnt=3 busy=1", cnt_a, busy_a);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy_a, match_a, done_a, cnt_a, busy_b, match_b, done_b, cnt_b} !== '0) begin
      n_bad++;
      $display("FAIL abort_reset: got busy=%b match=%b done=%b cnt=%0d want all 0",
               busy_a, match_a, done_a, cnt_a);
    end
    #1 reset_n = 1'b1;
    @(negedge clk);
    run_frame(3'b101, 3'b111, 1'b1, 16'h0015, 0, 16, 1'b1);
    n_cmp++;
    if (cnt_a !== 4'd2 || idx_a !== 4'd2 || sat_a !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_rerun: got cnt=%0d idx=%0d sat=%b want cnt=2 idx=2 sat=0", cnt_a, idx_a, sat_a);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_no_overlap();
    test_gaps();
    test_mask();
    test_saturate();
    test_abort();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
